// File: rtl/cs_enc_frame_arb.sv
// Round-robin frame arbiter in front of a block encoder: each grant feeds exactly three
// symbols from one requester, then waits for the encoder's output frame before re-arbitrating.
module cs_enc_frame_arb #(
    parameter int NREQ = 4,
    parameter int LIN  = 11,
    parameter int LOUT = 12,
    parameter int IDW  = 2
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [NREQ*LIN-1:0]  s_axis_tdata,
    input  logic [NREQ-1:0]      s_axis_tvalid,
    output logic [NREQ-1:0]      s_axis_tready,
    input  logic [NREQ-1:0]      s_axis_tlast,
    output logic [LIN-1:0]       enc_s_tdata,
    output logic                 enc_s_tvalid,
    input  logic                 enc_s_tready,
    output logic                 enc_s_tlast,
    input  logic [LOUT-1:0]      enc_m_tdata,
    input  logic                 enc_m_tvalid,
    output logic                 enc_m_tready,
    input  logic                 enc_m_tlast,
    output logic [LOUT-1:0]      m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [IDW-1:0]       m_axis_tid,
    output logic                 err_len,
    output logic [15:0]          frames_done
);

    typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2} state_t;

    state_t         state_reg, state_next;
    logic [IDW-1:0] grant_reg, grant_next;
    logic [IDW-1:0] last_grant_reg, last_grant_next;
    logic [1:0]     sym_cnt_reg, sym_cnt_next;
    logic           err_len_reg, err_len_next;
    logic [15:0]    frames_done_reg, frames_done_next;

    logic [LIN-1:0] req_data [NREQ];
    logic [NREQ-1:0] rr_rot;
    logic [IDW-1:0] rr_pick;
    logic           rr_found;
    logic           enc_s_hs, enc_m_hs, len_mismatch;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_data[gi]      = s_axis_tdata[gi*LIN +: LIN];
            assign s_axis_tready[gi] = (state_reg == FEED) && (grant_reg == IDW'(gi)) && enc_s_tready;
        end
    endgenerate

    assign enc_s_tdata  = req_data[grant_reg];
    assign enc_s_hs     = enc_s_tvalid && enc_s_tready;
    assign enc_m_hs     = enc_m_tvalid && m_axis_tready;
    assign len_mismatch = s_axis_tlast[grant_reg] != (sym_cnt_reg == 2'd2);

    assign m_axis_tdata  = enc_m_tdata;
    assign m_axis_tvalid = enc_m_tvalid;
    assign m_axis_tlast  = enc_m_tlast;
    assign enc_m_tready  = m_axis_tready;
    assign m_axis_tid    = grant_reg;
    assign err_len       = err_len_reg;
    assign frames_done   = frames_done_reg;

    // Rotate so bit k is requester (last_grant+1+k) mod NREQ; lowest set bit wins.
    always_comb begin
        rr_rot   = NREQ'({s_axis_tvalid, s_axis_tvalid} >> (int'(last_grant_reg) + 1));
        rr_found = 1'b0;
        rr_pick  = last_grant_reg;
        for (int k = 0; k < NREQ; k++) begin
            if (!rr_found && rr_rot[k]) begin
                rr_found = 1'b1;
                rr_pick  = IDW'((int'(last_grant_reg) + 1 + k) % NREQ);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            last_grant_reg  <= IDW'(NREQ - 1);
            sym_cnt_reg     <= '0;
            err_len_reg     <= 1'b0;
            frames_done_reg <= '0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            last_grant_reg  <= last_grant_next;
            sym_cnt_reg     <= sym_cnt_next;
            err_len_reg     <= err_len_next;
            frames_done_reg <= frames_done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        last_grant_next  = last_grant_reg;
        sym_cnt_next     = sym_cnt_reg;
        err_len_next     = 1'b0;
        frames_done_next = frames_done_reg;
        case (state_reg)
            IDLE: begin
                if (rr_found) begin
                    grant_next = rr_pick;
                    state_next = FEED;
                end
            end
            FEED: begin
                // The grant always spans three symbols; the requester's tlast is only audited.
                if (enc_s_hs) begin
                    err_len_next = len_mismatch;
                    if (sym_cnt_reg == 2'd2) begin
                        sym_cnt_next = 2'd0;
                        state_next   = DRAIN;
                    end else begin
                        sym_cnt_next = sym_cnt_reg + 2'd1;
                    end
                end
            end
            DRAIN: begin
                if (enc_m_hs && enc_m_tlast) begin
                    last_grant_next = grant_reg;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (enc_m_hs && enc_m_tlast && (state_reg != IDLE)) begin
            frames_done_next = frames_done_reg + 16'd1;
        end
    end

    always_comb begin
        enc_s_tvalid = 1'b0;
        enc_s_tlast  = 1'b0;
        if (state_reg == FEED) begin
            enc_s_tvalid = s_axis_tvalid[grant_reg];
            enc_s_tlast  = (sym_cnt_reg == 2'd2);
        end
    end

endmodule

// File: tb/tb_cs_enc_frame_arb.sv
// Directed bench for cs_enc_frame_arb with a 3-in/5-out encoder stub and a frame-level
// arbitration model that predicts every encoder-input symbol and every tagged output word.
module tb_cs_enc_frame_arb;
    localparam int NREQ = 4;
    localparam int LIN  = 11;
    localparam int LOUT = 12;
    localparam int IDW  = 2;

    logic                aclk = 1'b0;
    logic                aresetn;
    logic [NREQ*LIN-1:0] s_axis_tdata;
    logic [NREQ-1:0]     s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [LIN-1:0]      enc_s_tdata;
    logic                enc_s_tvalid, enc_s_tready, enc_s_tlast;
    logic [LOUT-1:0]     enc_m_tdata;
    logic                enc_m_tvalid, enc_m_tready, enc_m_tlast;
    logic [LOUT-1:0]     m_axis_tdata;
    logic                m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [IDW-1:0]      m_axis_tid;
    logic                err_len;
    logic [15:0]         frames_done;

    cs_enc_frame_arb #(.NREQ(NREQ), .LIN(LIN), .LOUT(LOUT), .IDW(IDW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .enc_s_tdata(enc_s_tdata), .enc_s_tvalid(enc_s_tvalid),
        .enc_s_tready(enc_s_tready), .enc_s_tlast(enc_s_tlast),
        .enc_m_tdata(enc_m_tdata), .enc_m_tvalid(enc_m_tvalid),
        .enc_m_tready(enc_m_tready), .enc_m_tlast(enc_m_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tid(m_axis_tid), .err_len(err_len), .frames_done(frames_done)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Requester symbol queues: {tlast, data}
    logic [LIN:0]      req_q [NREQ][$];
    // Expected encoder-input symbols {tid, tlast, data} and tagged outputs {tid, tlast, data}
    logic [IDW+LIN:0]  exp_enc_q [$];
    logic [IDW+LOUT:0] exp_m_q [$];
    logic [IDW+LOUT:0] obs_q [$];

    // Encoder stub: absorbs 3 symbols, then emits 5 words
    logic [LIN-1:0] eb [3];
    int             e_in, e_out;
    bit             e_busy;

    int          model_last;
    int          enc_pos;
    bit          drain_b;
    bit          err_pending;
    int          err_obs;
    logic [15:0] frames_exp;
    bit [2:0]    enc_last_hist;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LOUT-1:0] enc_word(input int k, input logic [LIN-1:0] a,
                                                 input logic [LIN-1:0] b, input logic [LIN-1:0] c);
        case (k)
            0:       return {1'b0, a};
            1:       return {1'b0, b};
            2:       return {1'b0, c};
            3:       return {1'b1, a ^ b};
            default: return {1'b1, b ^ c};
        endcase
    endfunction

    task automatic drive_req();
        logic [LIN:0] h;
        for (int i = 0; i < NREQ; i++) begin
            if (req_q[i].size() > 0) begin
                h = req_q[i][0];
                s_axis_tvalid[i] = 1'b1;
                s_axis_tlast[i]  = h[LIN];
                s_axis_tdata[i*LIN +: LIN] = h[LIN-1:0];
            end else begin
                s_axis_tvalid[i] = 1'b0;
                s_axis_tlast[i]  = 1'b0;
                s_axis_tdata[i*LIN +: LIN] = '0;
            end
        end
    endtask

    task automatic drive_enc();
        enc_s_tready = !e_busy;
        enc_m_tvalid = e_busy;
        enc_m_tlast  = e_busy && (e_out == 4);
        enc_m_tdata  = e_busy ? enc_word(e_out, eb[0], eb[1], eb[2]) : '0;
    endtask

    task automatic add_frame(input int r, input logic [LIN-1:0] d0, input logic [LIN-1:0] d1,
                             input logic [LIN-1:0] d2, input bit l0, input bit l1, input bit l2);
        req_q[r].push_back({l0, d0});
        req_q[r].push_back({l1, d1});
        req_q[r].push_back({l2, d2});
    endtask

    // Frame-level model: round-robin over requesters with queued frames, 3 in / 5 out each.
    task automatic plan();
        int pend [NREQ];
        int pos [NREQ];
        int pick;
        bit found;
        logic [LIN:0] s;
        logic [LIN-1:0] d [3];
        logic [IDW+LIN:0] ee;
        logic [IDW+LOUT:0] me;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = req_q[i].size() / 3;
            pos[i]  = 0;
        end
        while (1) begin
            found = 0;
            pick  = 0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!found && pend[(model_last + k) % NREQ] > 0) begin
                    found = 1;
                    pick  = (model_last + k) % NREQ;
                end
            end
            if (!found) break;
            for (int j = 0; j < 3; j++) begin
                s    = req_q[pick][pos[pick] + j];
                d[j] = s[LIN-1:0];
                ee   = {IDW'(pick), (j == 2), d[j]};
                exp_enc_q.push_back(ee);
            end
            for (int k = 0; k < 5; k++) begin
                me = {IDW'(pick), (k == 4), enc_word(k, d[0], d[1], d[2])};
                exp_m_q.push_back(me);
            end
            pend[pick]--;
            pos[pick] += 3;
            model_last = pick;
        end
    endtask

    // One clock: check at negedge, apply handshakes 1 time unit after posedge.
    task automatic step();
        bit               hs_enc, hs_m, err_now;
        bit [NREQ-1:0]    hs_req;
        logic [IDW+LIN:0] e;
        logic [IDW+LOUT:0] m, ob;
        logic [LIN:0]     h;
        logic [LIN-1:0]   enc_d;
        int               t;
        @(negedge aclk);
        chk("m_tdata_pass", m_axis_tdata, enc_m_tdata);
        chk("m_tvalid_pass", m_axis_tvalid, enc_m_tvalid);
        chk("m_tlast_pass", m_axis_tlast, enc_m_tlast);
        chk("enc_m_tready_pass", enc_m_tready, m_axis_tready);
        chk("err_len", err_len, err_pending);
        chk("frames_done", frames_done, frames_exp);
        if (err_len) err_obs++;
        if (drain_b) begin
            chk("drain_s_tready", s_axis_tready, 0);
            chk("drain_enc_tvalid", enc_s_tvalid, 0);
        end
        if (s_axis_tready != 0) begin
            chk("tready_grant", s_axis_tready, 1 << m_axis_tid);
            chk("enc_tvalid_mux", enc_s_tvalid, s_axis_tvalid[m_axis_tid]);
            chk("enc_tdata_mux", enc_s_tdata, s_axis_tdata[m_axis_tid*LIN +: LIN]);
        end
        hs_enc = enc_s_tvalid && enc_s_tready;
        hs_req = s_axis_tvalid & s_axis_tready;
        chk("req_enc_hs_pair", |hs_req, hs_enc);
        enc_d   = enc_s_tdata;
        err_now = 0;
        if (hs_enc) begin
            enc_last_hist = {enc_last_hist[1:0], enc_s_tlast};
            if (exp_enc_q.size() == 0) begin
                chk("unexpected_enc_sym", 1, 0);
            end else begin
                e = exp_enc_q.pop_front();
                chk("enc_s_tdata", enc_s_tdata, e[LIN-1:0]);
                chk("enc_s_tlast", enc_s_tlast, e[LIN]);
                chk("enc_s_tid", m_axis_tid, e[IDW+LIN:LIN+1]);
                t = int'(e[IDW+LIN:LIN+1]);
                if (req_q[t].size() > 0) begin
                    h = req_q[t][0];
                    err_now = (h[LIN] != (enc_pos == 2));
                end
            end
            if (enc_pos == 2) begin
                enc_pos = 0;
                drain_b = 1;
            end else begin
                enc_pos++;
            end
        end
        hs_m = enc_m_tvalid && enc_m_tready;
        if (hs_m) begin
            ob = {m_axis_tid, m_axis_tlast, m_axis_tdata};
            obs_q.push_back(ob);
            if (exp_m_q.size() == 0) begin
                chk("unexpected_m_word", 1, 0);
            end else begin
                m = exp_m_q.pop_front();
                chk("m_axis_tdata", m_axis_tdata, m[LOUT-1:0]);
                chk("m_axis_tlast", m_axis_tlast, m[LOUT]);
                chk("m_axis_tid", m_axis_tid, m[IDW+LOUT:LOUT+1]);
            end
            if (m_axis_tlast) begin
                frames_exp = frames_exp + 16'd1;
                drain_b = 0;
            end
        end
        @(posedge aclk);
        #1;
        err_pending = err_now;
        for (int i = 0; i < NREQ; i++) begin
            if (hs_req[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
        end
        if (hs_enc) begin
            eb[e_in] = enc_d;
            if (e_in == 2) begin
                e_in = 0; e_out = 0; e_busy = 1;
            end else begin
                e_in++;
            end
        end
        if (hs_m) begin
            if (e_out == 4) e_busy = 0;
            else e_out++;
        end
        drive_req();
        drive_enc();
    endtask

    task automatic run_frames(input int budget);
        int n = 0;
        while ((exp_m_q.size() > 0 || exp_enc_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("frame_timeout", n, 0);
        step();
        step();
    endtask

    task automatic reset_assert();
        aresetn = 1'b0;
        for (int i = 0; i < NREQ; i++) req_q[i].delete();
        exp_enc_q.delete();
        exp_m_q.delete();
        e_in = 0; e_out = 0; e_busy = 0;
        enc_pos = 0; drain_b = 0; err_pending = 0;
        frames_exp = 16'd0;
        model_last = NREQ - 1;
        drive_req();
        drive_enc();
    endtask

    task automatic reset_release();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_tready"}, s_axis_tready, 0);
        chk({tag, "_enc_tvalid"}, enc_s_tvalid, 0);
        chk({tag, "_enc_tlast"}, enc_s_tlast, 0);
        chk({tag, "_err_len"}, err_len, 0);
        chk({tag, "_frames_done"}, frames_done, 0);
        chk({tag, "_tid"}, m_axis_tid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [5];
        int e0, n;
        logic [IDW+LOUT:0] ob;
        logic [15:0] fd_before;
        logic [IDW+LOUT:0] held;

        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        err_obs = 0;
        enc_last_hist = '0;
        s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0;
        e_in = 0; e_out = 0; e_busy = 0;
        drive_enc();
        #2;

        // Single requester 2, well-formed frame; reset held with its tvalid up
        reset_assert();
        add_frame(2, 11'h001, 11'h002, 11'h403, 0, 0, 1);
        drive_req();
        repeat (2) @(posedge aclk);
        #1;
        chk_reset_outputs("rst");
        reset_release();
        obs_q.delete();
        e0 = err_obs;
        plan();
        run_frames(100);
        chk("s33_words", obs_q.size(), 5);
        if (obs_q.size() == 5) begin
            chk("s33_w0", obs_q[0], {2'd2, 1'b0, 12'h001});
            chk("s33_w3", obs_q[3], {2'd2, 1'b0, 12'h803});
            chk("s33_w4", obs_q[4], {2'd2, 1'b1, 12'hC01});
        end
        chk("s33_frames", frames_done, 16'd1);
        chk("s33_err", err_obs - e0, 0);

        // All four requesters continuously valid after reset
        @(posedge aclk); #1;
        reset_assert();
        for (int i = 0; i < NREQ; i++) begin
            for (int f = 0; f < ((i == 0) ? 2 : 1); f++) begin
                add_frame(i, 11'(i*256 + f*16 + 1), 11'(i*256 + f*16 + 2),
                          11'(i*256 + f*16 + 3), 0, 0, 1);
            end
        end
        drive_req();
        reset_release();
        obs_q.delete();
        plan();
        run_frames(300);
        order = '{0, 1, 2, 3, 0};
        chk("s34_words", obs_q.size(), 25);
        if (obs_q.size() == 25) begin
            for (int f = 0; f < 5; f++) begin
                for (int k = 0; k < 5; k++) begin
                    ob = obs_q[f*5 + k];
                    chk($sformatf("s34_tid_f%0d_w%0d", f, k), ob[IDW+LOUT:LOUT+1], order[f]);
                end
            end
        end
        chk("s34_frames", frames_done, 16'd5);

        // Requester 1 with early tlast on its 2nd symbol
        obs_q.delete();
        e0 = err_obs;
        enc_last_hist = '0;
        add_frame(1, 11'h111, 11'h222, 11'h333, 0, 1, 0);
        drive_req();
        plan();
        run_frames(100);
        chk("s35_err_pulses", err_obs - e0, 2);
        chk("s35_enc_tlast_pattern", enc_last_hist, 3'b001);
        chk("s35_words", obs_q.size(), 5);

        // Output stall of 10 cycles during DRAIN with a competing requester waiting
        obs_q.delete();
        add_frame(3, 11'h7A1, 11'h052, 11'h3C3, 0, 0, 1);
        add_frame(0, 11'h004, 11'h005, 11'h006, 0, 0, 1);
        drive_req();
        plan();
        n = 0;
        while (!drain_b && n < 50) begin step(); n++; end
        if (n >= 50) chk("s36_drain_timeout", n, 0);
        m_axis_tready = 1'b0;
        step();
        held = {m_axis_tid, m_axis_tlast, m_axis_tdata};
        fd_before = frames_done;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("s36_hold_data", {m_axis_tid, m_axis_tlast, m_axis_tdata}, held);
            chk("s36_hold_valid", m_axis_tvalid, 1);
            chk("s36_hold_tid", m_axis_tid, 3);
            chk("s36_competitor_tready", s_axis_tready, 0);
            chk("s36_frames_hold", frames_done, fd_before);
        end
        m_axis_tready = 1'b1;
        drive_enc();
        run_frames(200);
        chk("s36_words", obs_q.size(), 10);

        // Reset asserted after the 2nd FEED symbol
        add_frame(2, 11'h0AA, 11'h0BB, 11'h0CC, 0, 0, 1);
        drive_req();
        plan();
        n = 0;
        while (enc_pos != 2 && n < 50) begin step(); n++; end
        if (n >= 50) chk("s37_feed_timeout", n, 0);
        reset_assert();
        #1;
        chk_reset_outputs("s37");
        chk("s37_m_tvalid", m_axis_tvalid, 0);
        add_frame(1, 11'h101, 11'h102, 11'h103, 0, 0, 1);
        add_frame(2, 11'h201, 11'h202, 11'h203, 0, 0, 1);
        add_frame(0, 11'h001, 11'h002, 11'h003, 0, 0, 1);
        drive_req();
        reset_release();
        obs_q.delete();
        plan();
        run_frames(300);
        chk("s37_words", obs_q.size(), 15);
        if (obs_q.size() > 0) begin
            ob = obs_q[0];
            chk("s37_first_tid", ob[IDW+LOUT:LOUT+1], 0);
        end

        // frames_done wrap from 0xFFFF
        force dut.frames_done_reg = 16'hFFFF;
        frames_exp = 16'hFFFF;
        #2;
        release dut.frames_done_reg;
        step();
        chk("s38_preload", frames_done, 16'hFFFF);
        add_frame(3, 11'h011, 11'h022, 11'h033, 0, 0, 1);
        drive_req();
        plan();
        run_frames(100);
        chk("s38_wrap", frames_done, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
